// File: rtl/maindec_pipe.sv
// Main decoder with ID/EX stage register, load-use hazard detection and a bubble counter.
// Define MAINDEC_EXT_OPS_EN to also decode ADDI/SUBI/CBNZ/B.
module maindec_pipe #(
    parameter int CNTW = 16,
    parameter int XZR  = 31
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [10:0]     op_i,
    input  logic [4:0]      rn_i,
    input  logic [4:0]      rm_i,
    input  logic [4:0]      rd_i,
    input  logic            valid_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            Reg2Loc,
    output logic            ALUSrc,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            Branch,
    output logic            UncondBranch,
    output logic [1:0]      ALUOp,
    output logic [4:0]      rd_o,
    output logic            valid_o,
    output logic            illegal_o,
    output logic            hazard_o,
    output logic [CNTW-1:0] bubble_cnt_o
);

    localparam logic [4:0] XZR_IDX = 5'(XZR);

    // Control word layout: {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBranch, ALUOp}
    logic [9:0]      ctrl_dec_s;
    logic            illegal_dec_s;
    logic [4:0]      src2_s;
    logic            hazard_s;
    logic [9:0]      ctrl_r;
    logic [4:0]      rd_r;
    logic            valid_r;
    logic            illegal_r;
    logic [CNTW-1:0] cnt_r;

    // Opcode decode into the control word
    always_comb begin
        ctrl_dec_s    = 10'b00_0000_0000;
        illegal_dec_s = 1'b0;
        casez (op_i)
            11'b1?0_0101_1000,
            11'b10?_0101_0000: ctrl_dec_s = 10'b00_0100_0010;
            11'b101_1010_0???: ctrl_dec_s = 10'b10_0000_1001;
            11'b111_1100_0010: ctrl_dec_s = 10'b01_1110_0000;
            11'b111_1100_0000: ctrl_dec_s = 10'b11_0001_0000;
`ifdef MAINDEC_EXT_OPS_EN
            11'b100_1000_100?,
            11'b110_1000_100?: ctrl_dec_s = 10'b01_0100_0011;
            11'b101_1010_1???: ctrl_dec_s = 10'b10_0000_1001;
            11'b000_101?_????: ctrl_dec_s = 10'b00_0000_0100;
`endif
            default:           illegal_dec_s = 1'b1;
        endcase
    end

    // Load-use check against the load currently sitting in ID/EX
    always_comb begin
        if (ctrl_dec_s[9]) begin
            src2_s = rd_i;
        end else begin
            src2_s = rm_i;
        end
        hazard_s = valid_i & valid_r & ctrl_r[5] & (rd_r != XZR_IDX) &
                   ((rd_r == rn_i) | (rd_r == src2_s));
    end

    // ID/EX stage register and saturating bubble counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_r    <= 10'b00_0000_0000;
            rd_r      <= 5'd0;
            valid_r   <= 1'b0;
            illegal_r <= 1'b0;
            cnt_r     <= {CNTW{1'b0}};
        end else if (flush_i) begin
            ctrl_r    <= 10'b00_0000_0000;
            rd_r      <= 5'd0;
            valid_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else if (stall_i) begin
            ctrl_r    <= ctrl_r;
            rd_r      <= rd_r;
            valid_r   <= valid_r;
            illegal_r <= illegal_r;
        end else if (hazard_s) begin
            ctrl_r    <= 10'b00_0000_0000;
            rd_r      <= 5'd0;
            valid_r   <= 1'b0;
            illegal_r <= 1'b0;
            if (cnt_r != {CNTW{1'b1}}) begin
                cnt_r <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end else begin
            ctrl_r    <= valid_i ? ctrl_dec_s : 10'b00_0000_0000;
            rd_r      <= rd_i;
            valid_r   <= valid_i;
            illegal_r <= illegal_dec_s & valid_i;
        end
    end

    assign Reg2Loc      = ctrl_r[9];
    assign ALUSrc       = ctrl_r[8];
    assign MemtoReg     = ctrl_r[7];
    assign RegWrite     = ctrl_r[6];
    assign MemRead      = ctrl_r[5];
    assign MemWrite     = ctrl_r[4];
    assign Branch       = ctrl_r[3];
    assign UncondBranch = ctrl_r[2];
    assign ALUOp        = ctrl_r[1:0];
    assign rd_o         = rd_r;
    assign valid_o      = valid_r;
    assign illegal_o    = illegal_r;
    assign hazard_o     = hazard_s;
    assign bubble_cnt_o = cnt_r;

endmodule

// File: tb/tb_maindec_pipe.sv
// Scoreboard bench for maindec_pipe: a reference stage model pushes expected bundles, popped after each edge.
module tb_maindec_pipe;

    localparam int CW = 4;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_BAD  = 11'b00000000000;

    logic clk = 1'b0;
    logic reset;
    logic [10:0] op_i;
    logic [4:0] rn_i, rm_i, rd_i;
    logic valid_i, stall_i, flush_i;
    logic Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBranch;
    logic [1:0] ALUOp;
    logic [4:0] rd_o;
    logic valid_o, illegal_o, hazard_o;
    logic [CW-1:0] bubble_cnt_o;
    logic [16:0] dut_vec;

    int n_cmp = 0;
    int n_err = 0;

    // Reference stage state
    logic [9:0] m_ctrl;
    logic [4:0] m_rd;
    logic m_valid, m_illegal;
    logic [CW-1:0] m_cnt;
    logic [16:0] q_vec[$];
    logic [CW-1:0] q_cnt[$];

    logic [10:0] op_tab[11];

    maindec_pipe #(.CNTW(CW), .XZR(31)) dut (
        .clk(clk), .reset(reset), .op_i(op_i), .rn_i(rn_i), .rm_i(rm_i), .rd_i(rd_i),
        .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .UncondBranch(UncondBranch),
        .ALUOp(ALUOp), .rd_o(rd_o), .valid_o(valid_o), .illegal_o(illegal_o),
        .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o)
    );

    assign dut_vec = {valid_o, illegal_o, rd_o, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
                      MemRead, MemWrite, Branch, UncondBranch, ALUOp};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {illegal, R2L, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBranch, ALUOp}
    function automatic logic [10:0] ref_dec(input logic [10:0] op);
        logic [10:0] r;
        r = 11'b1_0000_0000_00;
        if ((op ==? 11'b1?0_0101_1000) || (op ==? 11'b10?_0101_0000)) r = 11'b0_0001_0000_10;
        if (op ==? 11'b101_1010_0???) r = 11'b0_1000_0010_01;
        if (op == 11'b111_1100_0010) r = 11'b0_0111_1000_00;
        if (op == 11'b111_1100_0000) r = 11'b0_1100_0100_00;
`ifdef MAINDEC_EXT_OPS_EN
        if ((op ==? 11'b100_1000_100?) || (op ==? 11'b110_1000_100?)) r = 11'b0_0101_0000_11;
        if (op ==? 11'b101_1010_1???) r = 11'b0_1000_0010_01;
        if (op ==? 11'b000_101?_????) r = 11'b0_0000_0001_00;
`endif
        return r;
    endfunction

    task automatic model_clear();
        m_ctrl = 10'd0; m_rd = 5'd0; m_valid = 1'b0; m_illegal = 1'b0; m_cnt = '0;
    endtask

    // One cycle: drive, check hazard, push model's next state, clock, pop and compare
    task automatic step(input logic [10:0] op, input logic [4:0] rn, input logic [4:0] rm,
                        input logic [4:0] rd, input logic v, input logic st, input logic fl);
        logic [10:0] d;
        logic [4:0] s2;
        logic h;
        logic [16:0] ev;
        logic [CW-1:0] ec;
        op_i = op; rn_i = rn; rm_i = rm; rd_i = rd; valid_i = v; stall_i = st; flush_i = fl;
        #2;
        d  = ref_dec(op);
        s2 = d[9] ? rd : rm;
        h  = v && m_valid && m_ctrl[5] && (m_rd != 5'd31) && ((m_rd == rn) || (m_rd == s2));
        check_eq("hazard", {31'd0, hazard_o}, {31'd0, h});
        if (fl || (!st && h)) begin
            if (!fl && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
            m_ctrl = 10'd0; m_rd = 5'd0; m_valid = 1'b0; m_illegal = 1'b0;
        end else if (!st) begin
            m_ctrl = v ? d[9:0] : 10'd0;
            m_rd = rd; m_valid = v; m_illegal = d[10] & v;
        end
        q_vec.push_back({m_valid, m_illegal, m_rd, m_ctrl});
        q_cnt.push_back(m_cnt);
        @(posedge clk);
        #1;
        ev = q_vec.pop_front();
        ec = q_cnt.pop_front();
        check_eq("bundle", {15'd0, dut_vec}, {15'd0, ev});
        check_eq("bubble_cnt", {{(32-CW){1'b0}}, bubble_cnt_o}, {{(32-CW){1'b0}}, ec});
    endtask

    initial begin
        op_tab = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_CBZ, OP_CBNZ, OP_LDUR, OP_STUR, OP_ADDI, OP_B, OP_BAD};
        reset = 1'b0;
        op_i = 11'd0; rn_i = 5'd0; rm_i = 5'd0; rd_i = 5'd0;
        valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_bundle", {15'd0, dut_vec}, 32'd0);
        check_eq("reset_cnt", {{(32-CW){1'b0}}, bubble_cnt_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // LDUR bundle, then load-use on rn and the single bubble
        step(OP_LDUR, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        step(OP_ADD,  5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        step(OP_ADD,  5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        // XZR destination is exempt
        step(OP_LDUR, 5'd1, 5'd2, 5'd31, 1'b1, 1'b0, 1'b0);
        step(OP_ADD,  5'd31, 5'd31, 5'd4, 1'b1, 1'b0, 1'b0);
        // Store data register via Reg2Loc path, and rm path
        step(OP_LDUR, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
        step(OP_STUR, 5'd3, 5'd9, 5'd7, 1'b1, 1'b0, 1'b0);
        step(OP_STUR, 5'd3, 5'd9, 5'd7, 1'b1, 1'b0, 1'b0);
        step(OP_LDUR, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        step(OP_SUB,  5'd3, 5'd8, 5'd1, 1'b1, 1'b0, 1'b0);
        step(OP_SUB,  5'd3, 5'd8, 5'd1, 1'b1, 1'b0, 1'b0);
        // STUR held by stall for three cycles, flushed on the last
        step(OP_STUR, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
        step(OP_ADD,  5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
        step(OP_ADD,  5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
        step(OP_ADD,  5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1);
        // Hazard during stall must not count
        step(OP_LDUR, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        step(OP_ADD,  5'd3, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0);
        step(OP_ADD,  5'd3, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1);
        // Remaining opcodes, illegal, and invalid slot
        step(OP_ADDI, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        step(OP_CBZ,  5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        step(OP_CBNZ, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        step(OP_B,    5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        step(OP_AND,  5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        step(OP_ORR,  5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        step(OP_BAD,  5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        step(OP_BAD,  5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        step(OP_LDUR, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
        // Drive the counter into saturation
        for (int i = 0; i < 18; i++) begin
            step(OP_LDUR, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
            step(OP_ADD,  5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
            step(OP_ADD,  5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        end
        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            step(op_tab[$urandom_range(0, 10)],
                 ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5)),
                 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0));
        end
        // Asynchronous reset mid-cycle while a stalled LDUR is held
        step(OP_LDUR, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
        step(OP_ADD,  5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_reset_bundle", {15'd0, dut_vec}, 32'd0);
        check_eq("async_reset_cnt", {{(32-CW){1'b0}}, bubble_cnt_o}, 32'd0);
        model_clear();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(OP_ADD,  5'd9, 5'd9, 5'd2, 1'b1, 1'b0, 1'b0);
        step(OP_STUR, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
